// File: rtl/clock_reset_seq.sv
// clock_reset_seq
//   Turns the MMCM LOCKED output into the system reset and the clock-enable strobes
//   for the 56 MHz domain. The core is held in reset until synchronised lock has
//   been stable for HOLD cycles. After that the block derives the 7 MHz pixel
//   enables and the 3.5 MHz CPU enables. Any loss of lock returns it to reset.
//
// Parameters
//   HOLD : cycles of stable synced lock needed before rst_n deasserts (>= 2)
//   HW   : hold counter width, 2**HW > HOLD
//
// Ports
//   clock  in   56 MHz clock (MMCM CLKOUT0 via BUFG)
//   reset  in   asynchronous active-low board/power-on reset
//   locked in   MMCM LOCKED, asynchronous to clock
//   rst_n  out  registered active-low system reset
//   ne7M   out  7 MHz negative-edge enable, 1-cycle pulse
//   pe7M   out  7 MHz positive-edge enable, 1-cycle pulse
//   ne3M5  out  3.5 MHz negative-edge enable, 1-cycle pulse
//   pe3M5  out  3.5 MHz positive-edge enable, 1-cycle pulse
//   losses out  saturating count of lock losses seen while running
module clock_reset_seq #(
  parameter int unsigned HOLD = 4096,
  parameter int unsigned HW   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked,
  output logic       rst_n,
  output logic       ne7M,
  output logic       pe7M,
  output logic       ne3M5,
  output logic       pe3M5,
  output logic [7:0] losses
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [HW-1:0] HOLD_TC = HW'(HOLD - 1);

  state_e        state_q, state_d;
  logic          sync1_q;
  logic          lk_q;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    phase_q, phase_d;
  logic          rst_n_q, rst_n_d;
  logic          ne7m_q, ne7m_d;
  logic          pe7m_q, pe7m_d;
  logic          ne3m5_q, ne3m5_d;
  logic          pe3m5_q, pe3m5_d;
  logic [7:0]    losses_q, losses_d;
  logic          run_ok;

  // Two-flop synchroniser. Nothing else in the block looks at locked.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      lk_q    <= 1'b0;
    end else begin
      sync1_q <= locked;
      lk_q    <= sync1_q;
    end
  end

  always_comb begin
    // The running window is reset released and lock still present. The phase
    // counter and the strobes are gated by this window. Because of that, the
    // strobes stop on the same edge where rst_n falls, and the phase starts at
    // 0 in the first cycle with rst_n high.
    run_ok   = rst_n_q & lk_q;

    state_d  = state_q;
    hold_d   = '0;
    losses_d = losses_q;

    unique case (state_q)
      ST_WAIT: begin
        if (lk_q) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // If lock drops on the terminal count, the drop takes priority.
        if (!lk_q)                  state_d = ST_WAIT;
        else if (hold_q == HOLD_TC) state_d = ST_RUN;
        else                        hold_d  = hold_q + 1'b1;
      end
      ST_RUN: begin
        if (!lk_q) begin
          state_d = ST_WAIT;
          if (losses_q != 8'hFF) losses_d = losses_q + 8'd1;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    rst_n_d = (state_q == ST_RUN) && lk_q;
    phase_d = run_ok ? phase_q + 4'd1 : '0;
    pe7m_d  = run_ok && (phase_q[2:0] == 3'd3);
    ne7m_d  = run_ok && (phase_q[2:0] == 3'd7);
    pe3m5_d = run_ok && (phase_q == 4'd7);
    ne3m5_d = run_ok && (phase_q == 4'd15);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_WAIT;
      hold_q   <= '0;
      phase_q  <= '0;
      rst_n_q  <= 1'b0;
      ne7m_q   <= 1'b0;
      pe7m_q   <= 1'b0;
      ne3m5_q  <= 1'b0;
      pe3m5_q  <= 1'b0;
      losses_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      phase_q  <= phase_d;
      rst_n_q  <= rst_n_d;
      ne7m_q   <= ne7m_d;
      pe7m_q   <= pe7m_d;
      ne3m5_q  <= ne3m5_d;
      pe3m5_q  <= pe3m5_d;
      losses_q <= losses_d;
    end
  end

  assign rst_n  = rst_n_q;
  assign ne7M   = ne7m_q;
  assign pe7M   = pe7m_q;
  assign ne3M5  = ne3m5_q;
  assign pe3M5  = pe3m5_q;
  assign losses = losses_q;

endmodule

// File: tb/tb_clock_reset_seq.sv
// tb_clock_reset_seq
//   Directed bench for clock_reset_seq with HOLD=8. Edges are counted from the
//   reset release. Every expected edge number below was worked out by hand.
module tb_clock_reset_seq;

  logic       clock;
  logic       reset;
  logic       locked;
  logic       rst_n;
  logic       ne7M;
  logic       pe7M;
  logic       ne3M5;
  logic       pe3M5;
  logic [7:0] losses;

  int unsigned checks = 0;
  int unsigned errors = 0;

  clock_reset_seq #(.HOLD(8), .HW(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .locked (locked),
    .rst_n  (rst_n),
    .ne7M   (ne7M),
    .pe7M   (pe7M),
    .ne3M5  (ne3M5),
    .pe3M5  (pe3M5),
    .losses (losses)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Apply reset, then release it 1 time unit after an edge. The next edge is edge 1.
  task automatic apply_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (!rst_n && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_pe7m();
    int k;
    k = 0;
    while (!pe7M && k < 20) begin
      tick();
      k++;
    end
  endtask

  initial begin
    int rise, fp, fn, fp3, fn3, n;
    int cnt_pe, cnt_ne, cnt_pe3, cnt_ne3, viol;
    int last_pe, last_ne, last_pe3, last_ne3, e, ne_after;

    reset  = 1'b0;
    locked = 1'b1;
    #2;
    chk("reset_rst_n",  rst_n,  0);
    chk("reset_enables", {ne7M, pe7M, ne3M5, pe3M5}, 0);
    chk("reset_losses", losses, 0);

    // Power-up timing. HOLD is entered on edge 3 and RUN on edge 11.
    // rst_n rises on edge 12. Phase 3 gives pe7M on edge 16 and phase 7 gives
    // ne7M and pe3M5 on edge 20.
    apply_reset();
    rise = 0; fp = 0; fn = 0; fp3 = 0; fn3 = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (rst_n && rise == 0) rise = i;
      if (pe7M  && fp  == 0)  fp   = i;
      if (ne7M  && fn  == 0)  fn   = i;
      if (pe3M5 && fp3 == 0)  fp3  = i;
    end
    chk("rise_edge",     rise, 12);
    chk("first_pe7m",    fp,   16);
    chk("first_ne7m",    fn,   20);
    chk("first_pe3m5",   fp3,  20);

    // Steady state over edges 21..84.
    cnt_pe = 0; cnt_ne = 0; cnt_pe3 = 0; cnt_ne3 = 0; viol = 0;
    last_pe = 16; last_ne = 20; last_pe3 = 20; last_ne3 = 0;
    for (int i = 21; i <= 84; i++) begin
      tick();
      if (pe7M && ne7M)   viol++;
      if (pe3M5 && !ne7M) viol++;
      if (pe7M)  begin cnt_pe++;  if (i - last_pe  != 8)  viol++; last_pe  = i; end
      if (ne7M)  begin cnt_ne++;  if (i - last_ne  != 8)  viol++; last_ne  = i; end
      if (pe3M5) begin cnt_pe3++; if (i - last_pe3 != 16) viol++; last_pe3 = i; end
      if (ne3M5) begin
        cnt_ne3++;
        if (fn3 == 0) fn3 = i;
        else if (i - last_ne3 != 16) viol++;
        last_ne3 = i;
      end
    end
    chk("cnt_pe7m",   cnt_pe,  8);
    chk("cnt_ne7m",   cnt_ne,  8);
    chk("cnt_pe3m5",  cnt_pe3, 4);
    chk("cnt_ne3m5",  cnt_ne3, 4);
    chk("first_ne3m5", fn3,    28);
    chk("strobe_viol", viol,   0);

    // Glitch during HOLD. locked is low between edges 8 and 9, while the count
    // is 5. lk is low only for the sample at edge 11. That is also the terminal
    // count, and the drop still returns the FSM to WAIT. HOLD is re-entered on
    // edge 12 and RUN on edge 20, so rst_n rises on edge 21.
    apply_reset();
    rise = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 8) locked = 1'b0;
      if (i == 9) locked = 1'b1;
      if (i == 12) chk("glitch_rst_n_low", rst_n, 0);
      if (rst_n && rise == 0) rise = i;
    end
    chk("glitch_rise_edge", rise, 21);
    chk("glitch_losses",    losses, 0);

    // Drop lock in RUN right after a pe7M. Phase 4 is current, lk falls with
    // phase 6, and rst_n falls on the third edge. Phase 7 must never decode.
    wait_pe7m();
    chk("drop_pe7m_found", pe7M, 1);
    locked = 1'b0;
    ne_after = 0;
    tick(); chk("drop_rst_n_e1", rst_n, 1); ne_after += int'(ne7M);
    tick(); chk("drop_rst_n_e2", rst_n, 1); ne_after += int'(ne7M);
    tick(); chk("drop_rst_n_e3", rst_n, 0); ne_after += int'(ne7M);
    chk("drop_losses", losses, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      ne_after += int'(ne7M | pe7M | ne3M5 | pe3M5);
    end
    chk("drop_no_strobes", ne_after, 0);

    // Restart. The phase begins again at 0 in the first cycle with rst_n high.
    locked = 1'b1;
    rise = 0; fp = 0; fn = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (rst_n && rise == 0) rise = i;
      if (pe7M  && fp == 0)   fp   = i;
      if (ne7M  && fn == 0)   fn   = i;
    end
    chk("restart_rise", rise, 12);
    chk("restart_pe7m_gap", fp - rise, 4);
    chk("restart_ne7m_gap", fn - rise, 8);

    // Saturation. This loop brings the total number of losses to 300.
    for (int i = 2; i <= 300; i++) begin
      locked = 1'b1;
      wait_rise(n);
      if (n >= 100) chk("sat_rise_timeout", n, 0);
      locked = 1'b0;
      tick(); tick(); tick();
      if (i == 254) chk("losses_254", losses, 254);
      if (i == 255) chk("losses_255", losses, 255);
    end
    chk("losses_sat", losses, 255);

    // Asynchronous reset while running.
    locked = 1'b1;
    wait_rise(n);
    chk("mid_run_rst_n", rst_n, 1);
    wait_pe7m();
    chk("mid_run_pe7m", pe7M, 1);
    reset = 1'b0;
    #1;
    chk("async_rst_n",   rst_n,  0);
    chk("async_enables", {ne7M, pe7M, ne3M5, pe3M5}, 0);
    chk("async_losses",  losses, 0);
    tick();
    reset = 1'b1;
    rise = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (rst_n && rise == 0) rise = i;
    end
    chk("after_async_rise", rise, 12);
    chk("after_async_losses", losses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
